// File: rtl/encounter_ctrl_if.sv
// Overworld <-> encounter controller bundle: movement/selection inputs and
// the registered battle/flash/enemy outputs consumed by the battle and sprite logic.
interface encounter_ctrl_if;
  logic [1:0] curr_map;
  logic [4:0] wild_ID;
  logic       step_pulse;
  logic       in_grass;
  logic       battle_done;
  logic       fight_on;
  logic       flash_on;
  logic       flash_phase;
  logic [4:0] enemy_ID;
  logic [1:0] enemy_map;
  logic [7:0] enc_count;

  modport master (
    output curr_map, wild_ID, step_pulse, in_grass, battle_done,
    input  fight_on, flash_on, flash_phase, enemy_ID, enemy_map, enc_count
  );

  modport slave (
    input  curr_map, wild_ID, step_pulse, in_grass, battle_done,
    output fight_on, flash_on, flash_phase, enemy_ID, enemy_map, enc_count
  );
endinterface

// File: rtl/encounter_ctrl.sv
// Wild-encounter sequencer: grass-step roll, flash transition, battle hold and
// post-battle step cooldown. Every output comes straight from a register.
module encounter_ctrl #(
  parameter int         ENC_THRESH     = 6,
  parameter int         FLASH_FRAMES   = 24,
  parameter int         FLASH_HALF     = 4,
  parameter int         COOLDOWN_STEPS = 3,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input logic          frameClk,
  input logic          Reset,
  encounter_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLASH, BATTLE, COOLDOWN} state_t;

  localparam logic [7:0] FRAMES_C = 8'(FLASH_FRAMES);
  localparam logic [7:0] HALF_C   = 8'(FLASH_HALF);
  localparam logic [3:0] COOL_C   = 4'(COOLDOWN_STEPS);
  localparam logic [4:0] THRESH_C = 5'(ENC_THRESH);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] half_cnt_q, half_cnt_d;
  logic [3:0] cool_cnt_q, cool_cnt_d;
  logic       fight_on_q, fight_on_d;
  logic       flash_on_q, flash_on_d;
  logic       flash_phase_q, flash_phase_d;
  logic [4:0] enemy_id_q, enemy_id_d;
  logic [1:0] enemy_map_q, enemy_map_d;
  logic [7:0] enc_count_q, enc_count_d;
  logic       roll_hit;

  // x^8+x^6+x^5+x^4+1 Fibonacci form; a nonzero seed keeps it off the all-zero lock-up state
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign roll_hit = ({1'b0, lfsr_q[3:0]} < THRESH_C);

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    half_cnt_d    = half_cnt_q;
    cool_cnt_d    = cool_cnt_q;
    fight_on_d    = fight_on_q;
    flash_on_d    = flash_on_q;
    flash_phase_d = flash_phase_q;
    enemy_id_d    = enemy_id_q;
    enemy_map_d   = enemy_map_q;
    enc_count_d   = enc_count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.step_pulse && bus.in_grass && roll_hit && (bus.wild_ID != 5'd0)) begin
          state_d       = FLASH;
          enemy_id_d    = bus.wild_ID;
          enemy_map_d   = bus.curr_map;
          enc_count_d   = (enc_count_q == 8'hFF) ? enc_count_q : enc_count_q + 8'd1;
          flash_on_d    = 1'b1;
          flash_phase_d = 1'b0;
          frame_cnt_d   = 8'd1;
          half_cnt_d    = 8'd1;
        end
      end
      FLASH: begin
        // counters hold the index of the flash frame currently on screen
        if (frame_cnt_q == FRAMES_C) begin
          state_d       = BATTLE;
          flash_on_d    = 1'b0;
          flash_phase_d = 1'b0;
          fight_on_d    = 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (half_cnt_q == HALF_C) begin
            half_cnt_d    = 8'd1;
            flash_phase_d = ~flash_phase_q;
          end else begin
            half_cnt_d = half_cnt_q + 8'd1;
          end
        end
      end
      BATTLE: begin
        if (bus.battle_done) begin
          state_d    = COOLDOWN;
          fight_on_d = 1'b0;
          cool_cnt_d = 4'd0;
        end
      end
      COOLDOWN: begin
        if (COOL_C == 4'd0) begin
          state_d = IDLE;
        end else if (bus.step_pulse) begin
          if (cool_cnt_q + 4'd1 == COOL_C) begin
            state_d = IDLE;
          end
          cool_cnt_d = cool_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frameClk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      lfsr_q        <= LFSR_SEED;
      frame_cnt_q   <= 8'd0;
      half_cnt_q    <= 8'd0;
      cool_cnt_q    <= 4'd0;
      fight_on_q    <= 1'b0;
      flash_on_q    <= 1'b0;
      flash_phase_q <= 1'b0;
      enemy_id_q    <= 5'd0;
      enemy_map_q   <= 2'd0;
      enc_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      frame_cnt_q   <= frame_cnt_d;
      half_cnt_q    <= half_cnt_d;
      cool_cnt_q    <= cool_cnt_d;
      fight_on_q    <= fight_on_d;
      flash_on_q    <= flash_on_d;
      flash_phase_q <= flash_phase_d;
      enemy_id_q    <= enemy_id_d;
      enemy_map_q   <= enemy_map_d;
      enc_count_q   <= enc_count_d;
    end
  end

  assign bus.fight_on    = fight_on_q;
  assign bus.flash_on    = flash_on_q;
  assign bus.flash_phase = flash_phase_q;
  assign bus.enemy_ID    = enemy_id_q;
  assign bus.enemy_map   = enemy_map_q;
  assign bus.enc_count   = enc_count_q;
endmodule

// File: tb/tb_encounter_ctrl.sv
// Bench for encounter_ctrl: three instances share the stimulus (always-roll, default
// roll, never-roll) and are checked against expectations built from the encounter rules.
module tb_encounter_ctrl;
  localparam logic [7:0] SEED = 8'hA5;

  logic       frameClk;
  logic       Reset;
  logic [1:0] curr_map;
  logic [4:0] wild_ID;
  logic       step_pulse, in_grass, battle_done;
  logic [7:0] m_lfsr;
  int         n_run, n_fail;

  encounter_ctrl_if if_a ();
  encounter_ctrl_if if_b ();
  encounter_ctrl_if if_c ();

  assign if_a.curr_map = curr_map;  assign if_a.wild_ID = wild_ID;  assign if_a.step_pulse = step_pulse;
  assign if_a.in_grass = in_grass;  assign if_a.battle_done = battle_done;
  assign if_b.curr_map = curr_map;  assign if_b.wild_ID = wild_ID;  assign if_b.step_pulse = step_pulse;
  assign if_b.in_grass = in_grass;  assign if_b.battle_done = battle_done;
  assign if_c.curr_map = curr_map;  assign if_c.wild_ID = wild_ID;  assign if_c.step_pulse = step_pulse;
  assign if_c.in_grass = in_grass;  assign if_c.battle_done = battle_done;

  encounter_ctrl #(.ENC_THRESH(16)) u_a (.frameClk(frameClk), .Reset(Reset), .bus(if_a));
  encounter_ctrl                    u_b (.frameClk(frameClk), .Reset(Reset), .bus(if_b));
  encounter_ctrl #(.ENC_THRESH(0))  u_c (.frameClk(frameClk), .Reset(Reset), .bus(if_c));

  initial frameClk = 1'b0;
  always #5 frameClk = ~frameClk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic fb;
    fb = ^(v & 8'hB8);
    return {v[6:0], fb};
  endfunction

  // Called right after a falling edge; returns at the next falling edge.
  task automatic drive_cycle(input logic sp, input logic ig, input logic bd);
    step_pulse = sp; in_grass = ig; battle_done = bd;
    @(negedge frameClk);
    step_pulse = 1'b0; in_grass = 1'b0; battle_done = 1'b0;
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    step_pulse = 1'b0; in_grass = 1'b0; battle_done = 1'b0;
    curr_map = 2'd0; wild_ID = 5'd0;
    @(negedge frameClk);
    @(negedge frameClk);
    Reset = 1'b1;
    m_lfsr = SEED;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 255; i++) begin
      n_run++;
      if (u_b.lfsr_q !== m_lfsr || u_b.lfsr_q == 8'd0) begin
        n_fail++;
        $display("FAIL lfsr step %0d: got %02h expected %02h", i, u_b.lfsr_q, m_lfsr);
      end
      drive_cycle(1'b0, 1'b0, 1'b0);
    end
    n_run++;
    if ({if_a.fight_on, if_a.flash_on, if_a.flash_phase, if_a.enemy_ID, if_a.enemy_map, if_a.enc_count} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {if_a.fight_on, if_a.flash_on, if_a.flash_phase, if_a.enemy_ID, if_a.enemy_map, if_a.enc_count});
    end
  endtask

  task automatic test_encounter();
    apply_reset();
    wild_ID = 5'b01101; curr_map = 2'b01;
    drive_cycle(1'b1, 1'b1, 1'b0);
    wild_ID = 5'b00111; curr_map = 2'b10;
    n_run++;
    if (if_a.enemy_ID !== 5'b01101 || if_a.enemy_map !== 2'b01 || if_a.enc_count !== 8'd1) begin
      n_fail++;
      $display("FAIL latch: got id=%0h map=%0h cnt=%0d expected id=d map=1 cnt=1",
               if_a.enemy_ID, if_a.enemy_map, if_a.enc_count);
    end
    for (int k = 1; k <= 24; k++) begin
      n_run++;
      if (if_a.flash_on !== 1'b1 || if_a.fight_on !== 1'b0 || if_a.flash_phase !== 1'(((k - 1) / 4) % 2)) begin
        n_fail++;
        $display("FAIL flash T+%0d: got on=%b ph=%b fight=%b expected on=1 ph=%0d fight=0",
                 k, if_a.flash_on, if_a.flash_phase, if_a.fight_on, ((k - 1) / 4) % 2);
      end
      drive_cycle((k % 3) == 0, 1'b1, (k % 5) == 0);
    end
    n_run++;
    if (if_a.fight_on !== 1'b1 || if_a.flash_on !== 1'b0 || if_a.flash_phase !== 1'b0) begin
      n_fail++;
      $display("FAIL fight_start T+25: got fight=%b on=%b ph=%b expected 1 0 0",
               if_a.fight_on, if_a.flash_on, if_a.flash_phase);
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);
    end
    n_run++;
    if (if_a.fight_on !== 1'b1 || if_a.enemy_ID !== 5'b01101 || if_a.enemy_map !== 2'b01 || if_a.enc_count !== 8'd1) begin
      n_fail++;
      $display("FAIL battle_hold: got fight=%b id=%0h map=%0h cnt=%0d expected 1 d 1 1",
               if_a.fight_on, if_a.enemy_ID, if_a.enemy_map, if_a.enc_count);
    end
    drive_cycle(1'b1, 1'b1, 1'b1);
    n_run++;
    if (if_a.fight_on !== 1'b0) begin
      n_fail++;
      $display("FAIL battle_done: got fight=%b expected 0", if_a.fight_on);
    end
    for (int s = 1; s <= 4; s++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      n_run++;
      if (if_a.enc_count !== ((s == 4) ? 8'd2 : 8'd1) || if_a.flash_on !== (s == 4)) begin
        n_fail++;
        $display("FAIL cooldown step %0d: got cnt=%0d flash=%b expected cnt=%0d flash=%b",
                 s, if_a.enc_count, if_a.flash_on, (s == 4) ? 2 : 1, s == 4);
      end
      drive_cycle(1'b0, 1'b0, 1'b0);
    end
    n_run++;
    if (if_a.enemy_ID !== 5'b00111 || if_a.enemy_map !== 2'b10) begin
      n_fail++;
      $display("FAIL relatch: got id=%0h map=%0h expected 7 2", if_a.enemy_ID, if_a.enemy_map);
    end
  endtask

  task automatic test_no_encounter();
    apply_reset();
    curr_map = 2'd3;
    for (int i = 0; i < 50; i++) begin
      wild_ID = 5'd9;
      drive_cycle(1'b1, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b0);
      wild_ID = 5'd0;
      drive_cycle(1'b1, 1'b1, 1'b0);
    end
    n_run++;
    if (if_a.enc_count !== 8'd0 || if_a.flash_on !== 1'b0 || if_a.enemy_ID !== 5'd0) begin
      n_fail++;
      $display("FAIL no_grass_or_invalid: got cnt=%0d flash=%b id=%0h expected 0 0 0",
               if_a.enc_count, if_a.flash_on, if_a.enemy_ID);
    end
    wild_ID = 5'd17;
    for (int i = 0; i < 50; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      n_run++;
      if (if_c.enc_count !== 8'd0 || if_c.flash_on !== 1'b0) begin
        n_fail++;
        $display("FAIL thresh0 step %0d: got cnt=%0d flash=%b expected 0 0", i, if_c.enc_count, if_c.flash_on);
      end
    end
  endtask

  task automatic test_reset_mid();
    int flash_cycles;
    apply_reset();
    wild_ID = 5'd4; curr_map = 2'd2;
    drive_cycle(1'b1, 1'b1, 1'b0);
    repeat (9) drive_cycle(1'b0, 1'b0, 1'b0);
    #2 Reset = 1'b0;
    #1;
    n_run++;
    if ({if_a.fight_on, if_a.flash_on, if_a.flash_phase, if_a.enemy_ID, if_a.enemy_map, if_a.enc_count} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_in_flash: got %0h expected 0",
               {if_a.fight_on, if_a.flash_on, if_a.flash_phase, if_a.enemy_ID, if_a.enemy_map, if_a.enc_count});
    end
    @(negedge frameClk);
    Reset = 1'b1; m_lfsr = SEED;
    drive_cycle(1'b1, 1'b1, 1'b0);
    flash_cycles = 0;
    while (if_a.flash_on === 1'b1 && flash_cycles < 40) begin
      flash_cycles++;
      drive_cycle(1'b0, 1'b0, 1'b0);
    end
    n_run++;
    if (flash_cycles != 24 || if_a.fight_on !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_flash: got %0d frames fight=%b expected 24 frames fight=1", flash_cycles, if_a.fight_on);
    end
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
    #2 Reset = 1'b0;
    #1;
    n_run++;
    if (if_a.fight_on !== 1'b0 || if_a.enc_count !== 8'd0 || if_a.enemy_ID !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_in_battle: got fight=%b cnt=%0d id=%0h expected 0 0 0",
               if_a.fight_on, if_a.enc_count, if_a.enemy_ID);
    end
    @(negedge frameClk);
    Reset = 1'b1; m_lfsr = SEED;
  endtask

  task automatic test_saturation();
    apply_reset();
    wild_ID = 5'd1;
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      n_run++;
      if (if_a.enc_count !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
        n_fail++;
        $display("FAIL sat encounter %0d: got %0d expected %0d", i, if_a.enc_count, (i + 1 > 255) ? 255 : i + 1);
      end
      repeat (24) drive_cycle(1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b1);
      repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
    end
    n_run++;
    if (if_c.enc_count !== 8'd0) begin
      n_fail++;
      $display("FAIL thresh0_sat: got %0d expected 0", if_c.enc_count);
    end
  endtask

  // Encounter timeline model: age = frames since the encounter step, csteps = cooldown steps seen.
  task automatic test_random();
    int mode, age, csteps, e_cnt;
    logic [4:0] e_id;
    logic [1:0] e_map;
    logic sp, ig, bd, x_flash, x_phase, x_fight;
    apply_reset();
    mode = 0; age = 0; csteps = 0; e_cnt = 0; e_id = 5'd0; e_map = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      sp = ($urandom_range(0, 2) == 0);
      ig = $urandom_range(0, 1) == 1;
      bd = ($urandom_range(0, 5) == 0);
      wild_ID  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      curr_map = 2'($urandom_range(0, 3));
      if (mode == 0) begin
        if (sp && ig && m_lfsr[3:0] < 4'd6 && wild_ID != 5'd0) begin
          mode = 1; age = 1; e_id = wild_ID; e_map = curr_map;
          if (e_cnt < 255) e_cnt++;
        end
      end else if (mode == 1) begin
        if (age > 24 && bd) begin
          mode = 2; csteps = 0;
        end else begin
          age++;
        end
      end else if (sp) begin
        csteps++;
        if (csteps == 3) mode = 0;
      end
      drive_cycle(sp, ig, bd);
      x_flash = (mode == 1) && (age <= 24);
      x_phase = x_flash && (((age - 1) / 4) % 2 == 1);
      x_fight = (mode == 1) && (age > 24);
      n_run++;
      if ({if_b.fight_on, if_b.flash_on, if_b.flash_phase, if_b.enemy_ID, if_b.enemy_map, if_b.enc_count}
          !== {x_fight, x_flash, x_phase, e_id, e_map, 8'(e_cnt)}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got fight=%b flash=%b ph=%b id=%0h map=%0h cnt=%0d expected %b %b %b %0h %0h %0d",
                 n, if_b.fight_on, if_b.flash_on, if_b.flash_phase, if_b.enemy_ID, if_b.enemy_map, if_b.enc_count,
                 x_fight, x_flash, x_phase, e_id, e_map, e_cnt);
      end
    end
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    test_reset();
    test_encounter();
    test_no_encounter();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
